// File: rtl/crc_pkg.sv
// Shared types and helpers for the parametrised CRC framer.
// Build option: CRC_REFLECT_EN selects reflected input/output CRC operation.
package crc_pkg;

    typedef enum logic {
        S_DATA = 1'b0,
        S_CRC  = 1'b1
    } state_e;

    // Word count for the default 8-bit CRC over 8-bit words; the top derives
    // its own from its actual CRC_W/DATA_W.
    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_CRC_W  = 8;
    localparam int unsigned K          = DEF_CRC_W / DEF_DATA_W;

    // Bit-reverse the low `width` bits of value (width <= 32), upper bits zero.
    function automatic logic [31:0] reflect(input logic [31:0] value, input int width);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < width) r[i] = value[width - 1 - i];
        end
        return r;
    endfunction

endpackage

// File: rtl/crc_step.sv
// One-cycle parallel CRC update: MSB-first, non-reflected, DATA_W bits per call.
module crc_step
    import crc_pkg::*;
#(
    parameter int unsigned      DATA_W = 8,
    parameter int unsigned      CRC_W  = 8,
    parameter logic [CRC_W-1:0] POLY   = 8'h07
) (
    input  logic [CRC_W-1:0]  crc_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [CRC_W-1:0]  crc_o
);

    logic [CRC_W-1:0] c;

    // NOTE: blocking assignments here on purpose; each unrolled bit step must
    // see the result of the previous one within the same evaluation.
    always_comb begin
        c = crc_i;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            if (c[CRC_W-1] ^ data_i[i]) c = (c << 1) ^ POLY;
            else                        c = c << 1;
        end
        crc_o = c;
    end

endmodule

// File: rtl/crc_framer.sv
// Frame echo + CRC appender with back-pressure, abort and overrun flag.
// Build option: define CRC_REFLECT_EN for reflected (LSB-first) CRC standards.
module crc_framer
    import crc_pkg::*;
#(
    parameter int unsigned      DATA_W    = 8,
    parameter int unsigned      CRC_W     = 8,
    parameter logic [CRC_W-1:0] POLY      = 8'h07,
    parameter logic [CRC_W-1:0] INIT      = '0,
    parameter logic [CRC_W-1:0] XOR_OUT   = '0,
    parameter int unsigned      FRAME_LEN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              crc_en,
    input  logic [DATA_W-1:0] dina,
    input  logic              crc_clr,
    output logic              crc_rdy,
    output logic              crc_vld,
    output logic [DATA_W-1:0] crc_dout,
    output logic              crc_last,
    output logic              crc_err
);

    localparam int unsigned      NUM_WORDS = CRC_W / DATA_W;
    localparam int unsigned      CNT_W     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int unsigned      IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAME_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_WORDS - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CRC_W-1:0]  crc_q, crc_d;
    logic [CRC_W-1:0]  shift_q, shift_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              vld_q, vld_d;
    logic              last_q, last_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] step_data;
    logic [CRC_W-1:0]  step_crc;
    logic [CRC_W-1:0]  crc_final;

`ifdef CRC_REFLECT_EN
    assign step_data = DATA_W'(reflect(32'(dina), DATA_W));
    assign crc_final = CRC_W'(reflect(32'(step_crc), CRC_W)) ^ XOR_OUT;
`else
    assign step_data = dina;
    assign crc_final = step_crc ^ XOR_OUT;
`endif

    crc_step #(
        .DATA_W (DATA_W),
        .CRC_W  (CRC_W),
        .POLY   (POLY)
    ) u_step (
        .crc_i  (crc_q),
        .data_i (step_data),
        .crc_o  (step_crc)
    );

    assign crc_rdy = (state_q == S_DATA);

    // NOTE: every variable gets a default before the case so no path infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        crc_d   = crc_q;
        shift_d = shift_q;
        dout_d  = dout_q;
        vld_d   = 1'b0;
        last_d  = 1'b0;
        err_d   = crc_en & ~crc_rdy;

        if (crc_clr) begin
            state_d = S_DATA;
            cnt_d   = '0;
            idx_d   = '0;
            crc_d   = INIT;
        end else begin
            case (state_q)
                S_DATA: begin
                    if (crc_en) begin
                        dout_d = dina;
                        vld_d  = 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            // CRC register is re-armed now; the result lives in the shifter.
                            shift_d = crc_final;
                            crc_d   = INIT;
                            cnt_d   = '0;
                            idx_d   = '0;
                            state_d = S_CRC;
                        end else begin
                            crc_d = step_crc;
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                S_CRC: begin
                    dout_d  = shift_q[CRC_W-1 -: DATA_W];
                    shift_d = shift_q << DATA_W;
                    vld_d   = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        last_d  = 1'b1;
                        idx_d   = '0;
                        state_d = S_DATA;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                default: state_d = S_DATA;
            endcase
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_DATA;
            cnt_q   <= '0;
            idx_q   <= '0;
            crc_q   <= INIT;
            shift_q <= '0;
            dout_q  <= '0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            crc_q   <= crc_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    assign crc_vld  = vld_q;
    assign crc_dout = dout_q;
    assign crc_last = last_q;
    assign crc_err  = err_q;

endmodule

// File: tb/tb_crc_framer.sv
// Scoreboard bench: CRC-8 (or CRC-8/MAXIM with CRC_REFLECT_EN) and CRC-16 instances.
module tb_crc_framer;

`ifdef CRC_REFLECT_EN
    localparam logic [7:0] POLY8 = 8'h31;
    localparam int         LEN8  = 9;
`else
    localparam logic [7:0] POLY8 = 8'h07;
    localparam int         LEN8  = 4;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic       en8 = 1'b0, clr8 = 1'b0;
    logic [7:0] dina8 = '0;
    logic       rdy8, vld8, last8, err8;
    logic [7:0] dout8;

    logic       en16 = 1'b0, clr16 = 1'b0;
    logic [7:0] dina16 = '0;
    logic       rdy16, vld16, last16, err16;
    logic [7:0] dout16;

    logic [8:0] exp8_q[$];
    logic [8:0] exp16_q[$];
    logic [7:0] ascii9 [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

    int n_checks = 0;
    int n_fail   = 0;
    int err8_cnt = 0;
    int err16_cnt = 0;

    always #5 clk = ~clk;

    crc_framer #(
        .DATA_W(8), .CRC_W(8), .POLY(POLY8), .INIT(8'h00), .XOR_OUT(8'h00), .FRAME_LEN(LEN8)
    ) u_dut8 (
        .clk(clk), .rst(rst), .crc_en(en8), .dina(dina8), .crc_clr(clr8),
        .crc_rdy(rdy8), .crc_vld(vld8), .crc_dout(dout8), .crc_last(last8), .crc_err(err8)
    );

    crc_framer #(
        .DATA_W(8), .CRC_W(16), .POLY(16'h1021), .INIT(16'h0000), .XOR_OUT(16'h0000), .FRAME_LEN(9)
    ) u_dut16 (
        .clk(clk), .rst(rst), .crc_en(en16), .dina(dina16), .crc_clr(clr16),
        .crc_rdy(rdy16), .crc_vld(vld16), .crc_dout(dout16), .crc_last(last16), .crc_err(err16)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitors: pop the scoreboard whenever an output word is presented.
    always @(negedge clk) begin
        if (rst) begin
            if (err8) err8_cnt++;
            if (vld8) begin
                if (exp8_q.size() == 0) begin
                    check("dut8_spurious_vld", 32'(dout8), 32'hFFFF_FFFF);
                end else begin
                    logic [8:0] e;
                    e = exp8_q.pop_front();
                    check("dut8_dout", 32'(dout8), 32'(e[7:0]));
                    check("dut8_last", 32'(last8), 32'(e[8]));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (err16) err16_cnt++;
            if (vld16) begin
                if (exp16_q.size() == 0) begin
                    check("dut16_spurious_vld", 32'(dout16), 32'hFFFF_FFFF);
                end else begin
                    logic [8:0] e;
                    e = exp16_q.pop_front();
                    check("dut16_dout", 32'(dout16), 32'(e[7:0]));
                    check("dut16_last", 32'(last16), 32'(e[8]));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive8(input logic [7:0] d, input bit accept, input int gap);
        en8   = 1'b1;
        dina8 = d;
        if (accept) exp8_q.push_back({1'b0, d});
        tick();
        en8 = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic drive16(input logic [7:0] d);
        en16   = 1'b1;
        dina16 = d;
        exp16_q.push_back({1'b0, d});
        tick();
        en16 = 1'b0;
    endtask

    task automatic frame_0302(input int gap);
        drive8(8'h03, 1'b1, gap);
        drive8(8'h00, 1'b1, gap);
        drive8(8'h01, 1'b1, gap);
        drive8(8'h02, 1'b1, gap);
        exp8_q.push_back({1'b1, 8'h21});
    endtask

    task automatic drain8(input string name);
        int n = 0;
        while (exp8_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        check(name, 32'(exp8_q.size()), 32'd0);
        tick();
    endtask

    task automatic drain16(input string name);
        int n = 0;
        while (exp16_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        check(name, 32'(exp16_q.size()), 32'd0);
        tick();
    endtask

    initial begin
        int lo;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_vld", 32'(vld8), 32'd0);
        check("rst_dout", 32'(dout8), 32'd0);
        check("rst_last", 32'(last8), 32'd0);
        check("rst_err", 32'(err8), 32'd0);
        check("rst_rdy", 32'(rdy8), 32'd1);
        check("rst_rdy16", 32'(rdy16), 32'd1);
        rst = 1'b1;
        tick();

`ifdef CRC_REFLECT_EN
        // CRC-8/MAXIM and CRC-16/KERMIT check strings
        for (int i = 0; i < 9; i++) drive8(ascii9[i], 1'b1, 0);
        exp8_q.push_back({1'b1, 8'hA1});
        drain8("maxim_drain");
        for (int i = 0; i < 9; i++) drive16(ascii9[i]);
        exp16_q.push_back({1'b0, 8'h21});
        exp16_q.push_back({1'b1, 8'h89});
        drain16("kermit_drain");
        check("err8_pulses", 32'(err8_cnt), 32'd0);
`else
        // Frame with one-cycle gaps
        frame_0302(1);
        drain8("gap_frame_drain");

        // Overrun during CRC emission: word dropped, err pulses once
        frame_0302(0);
        check("rdy_low_in_crc", 32'(rdy8), 32'd0);
        en8   = 1'b1;
        dina8 = 8'hFF;
        tick();
        en8 = 1'b0;
        check("err_pulse", 32'(err8), 32'd1);
        tick();
        check("err_cleared", 32'(err8), 32'd0);
        check("rdy_back", 32'(rdy8), 32'd1);
        frame_0302(0);
        drain8("after_overrun_drain");

        // Abort after two words; clr beats a simultaneous en
        drive8(8'h03, 1'b1, 0);
        drive8(8'h00, 1'b1, 0);
        clr8  = 1'b1;
        en8   = 1'b1;
        dina8 = 8'h55;
        tick();
        clr8 = 1'b0;
        en8  = 1'b0;
        check("clr_vld_low", 32'(vld8), 32'd0);
        frame_0302(1);
        drain8("after_clr_drain");

        // Reset while in S_CRC
        drive8(8'h03, 1'b1, 0);
        drive8(8'h00, 1'b1, 0);
        drive8(8'h01, 1'b1, 0);
        drive8(8'h02, 1'b0, 0);
        rst = 1'b0;
        #1;
        check("midrst_vld", 32'(vld8), 32'd0);
        check("midrst_dout", 32'(dout8), 32'd0);
        check("midrst_last", 32'(last8), 32'd0);
        check("midrst_err", 32'(err8), 32'd0);
        check("midrst_rdy", 32'(rdy8), 32'd1);
        tick();
        tick();
        check("midrst_flush", 32'(exp8_q.size()), 32'd0);
        rst = 1'b1;
        tick();
        frame_0302(0);
        drain8("after_rst_drain");

        // CRC-16/XMODEM on "123456789", back to back
        for (int i = 0; i < 9; i++) drive16(ascii9[i]);
        exp16_q.push_back({1'b0, 8'h31});
        exp16_q.push_back({1'b1, 8'hC3});
        lo = 0;
        while (!rdy16 && lo < 10) begin
            lo++;
            tick();
        end
        check("crc16_rdy_low_cycles", 32'(lo), 32'd2);
        drain16("crc16_drain");
        check("err8_pulses", 32'(err8_cnt), 32'd1);
`endif
        check("err16_pulses", 32'(err16_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
